// File: rtl/display_scan_driver.sv
// display_scan_driver
// Eight-entry character register file driving a multiplexed 8-digit
// common-anode seven-segment display. Each digit slot lasts REFRESH_DIV
// clocks, opens with BLANK_CYCLES of all-anodes-off, and FRAME pulses
// alongside the first output cycle of digit 0.
module display_scan_driver #(
   parameter int REFRESH_DIV  = 100000,
   parameter int BLANK_CYCLES = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       W,
   input  logic [2:0] WADD,
   input  logic [5:0] DIN,
   output logic [7:0] AN,
   output logic [6:0] SEG,
   output logic       DP,
   output logic       FRAME
);

   localparam int PCNT_W = $clog2(REFRESH_DIV);
   localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(REFRESH_DIV - 1);
   localparam logic [PCNT_W-1:0] BLANK_END = PCNT_W'(BLANK_CYCLES);

   // Active-low {g,f,e,d,c,b,a} pattern for a hex nibble
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   logic [5:0]        mem [8];
   logic [PCNT_W-1:0] pcnt;
   logic [2:0]        d;
   logic              frame_p0;

   logic [5:0] e;
   logic       slot_last;
   logic       blank;
   logic [7:0] an_next;

   assign e         = mem[d];
   assign slot_last = (pcnt == PCNT_LAST);
   // BLANK_CYCLES of zero means no guard interval at all
   assign blank     = (BLANK_CYCLES != 0) && (pcnt < BLANK_END);
   assign an_next   = (blank || !e[5]) ? 8'hFF : ~(8'b1 << d);

   // Register file: last write wins; reset disables every digit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 8; i++) mem[i] <= '0;
      end else if (W) begin
         mem[WADD] <= DIN;
      end
   end

   // Scan position: prescaler within the slot, digit index across slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pcnt     <= '0;
         d        <= '0;
         frame_p0 <= 1'b0;
      end else begin
         frame_p0 <= slot_last && (d == 3'd7);
         if (slot_last) begin
            pcnt <= '0;
            d    <= d + 3'd1;
         end else begin
            pcnt <= pcnt + 1'b1;
         end
      end
   end

   // Output register: presents the state that preceded this edge, so FRAME
   // is delayed one cycle to land on digit 0's first presented cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         AN    <= 8'hFF;
         SEG   <= 7'h7F;
         DP    <= 1'b1;
         FRAME <= 1'b0;
      end else begin
         AN    <= an_next;
         SEG   <= hex7(e[4:1]);
         DP    <= e[0];
         FRAME <= frame_p0;
      end
   end

endmodule

// File: tb/tb_display_scan_driver.sv
// Scoreboard bench for display_scan_driver. A reference model maps the
// number of cycles since reset release onto (digit, position in slot)
// arithmetically and predicts each output edge; a monitor compares them.
module tb_display_scan_driver;

   localparam int DIV   = 8;
   localparam int BLANK = 2;
   localparam int FRM   = 8 * DIV;

   logic       clk;
   logic       rst_n;
   logic       W;
   logic [2:0] WADD;
   logic [5:0] DIN;
   logic [7:0] AN;
   logic [6:0] SEG;
   logic       DP;
   logic       FRAME;

   display_scan_driver #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
      .clk(clk), .rst_n(rst_n), .W(W), .WADD(WADD), .DIN(DIN),
      .AN(AN), .SEG(SEG), .DP(DP), .FRAME(FRAME)
   );

   typedef struct {
      int         en;
      logic [7:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       frame;
   } exp_t;

   exp_t       q[$];
   int         checks;
   int         failures;
   int         ecnt;
   int         s;
   logic [5:0] ent [8];
   logic [6:0] hexref [16];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) ecnt <= ecnt + 1;

   // Predict the output after the next edge, then apply this cycle's write
   task automatic model_step(input logic w, input logic [2:0] a, input logic [5:0] din);
      exp_t x;
      int   dg;
      int   pc;
      logic [5:0] e;
      dg = (s / DIV) % 8;
      pc = s % DIV;
      e  = ent[dg];
      x.en    = ecnt + 1;
      x.seg   = hexref[e[4:1]];
      x.dp    = e[0];
      x.an    = 8'hFF;
      if (pc >= BLANK && e[5]) x.an[dg] = 1'b0;
      x.frame = (s > 0) && (s % FRM == 0);
      q.push_back(x);
      if (w) ent[a] = din;
      s++;
   endtask

   task automatic tick(input logic w, input logic [2:0] a, input logic [5:0] din);
      @(posedge clk);
      #1;
      W = w; WADD = a; DIN = din;
      model_step(w, a, din);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick(1'b0, 3'd0, 6'd0);
   endtask

   task automatic model_reset();
      q.delete();
      for (int i = 0; i < 8; i++) ent[i] = 6'd0;
      s = 0;
   endtask

   task automatic release_reset();
      @(posedge clk);
      #1;
      W = 1'b0;
      rst_n = 1'b1;
      model_step(1'b0, 3'd0, 6'd0);
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if (AN !== 8'hFF || SEG !== 7'h7F || DP !== 1'b1 || FRAME !== 1'b0) begin
         failures++;
         $display("FAIL %s got AN=%h SEG=%h DP=%b FRAME=%b want AN=ff SEG=7f DP=1 FRAME=0",
                  tag, AN, SEG, DP, FRAME);
      end
   endtask

   // Monitor: compare every predicted edge once the DUT has presented it
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #2;
         while (q.size() > 0 && q[0].en <= ecnt) begin
            x = q.pop_front();
            checks++;
            if (AN !== x.an || SEG !== x.seg || DP !== x.dp || FRAME !== x.frame) begin
               failures++;
               $display("FAIL scan edge=%0d got AN=%h SEG=%h DP=%b FRAME=%b want AN=%h SEG=%h DP=%b FRAME=%b",
                        x.en, AN, SEG, DP, FRAME, x.an, x.seg, x.dp, x.frame);
            end
         end
      end
   end

   initial begin
      logic [3:0] nib;
      hexref = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
      checks = 0; failures = 0; ecnt = 0;
      rst_n = 1'b0; W = 1'b0; WADD = 3'd0; DIN = 6'd0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset_initial");
      release_reset();

      // No writes: display stays dark for more than a frame
      idle(70);

      // Full frame: entries 7..0 = {1, n, 1} back to back, then watch frames
      for (int n = 7; n >= 0; n--) begin
         nib = 4'(n);
         tick(1'b1, 3'(n), {1'b1, nib, 1'b1});
      end
      idle(3 * FRM);

      // Decode sweep on digit 0, one frame per nibble
      for (int n = 0; n < 16; n++) begin
         nib = 4'(n);
         tick(1'b1, 3'd0, {1'b1, nib, 1'b0});
         idle(FRM - 1);
      end

      // Disabled digit stays dark; then enabled with DP lit
      tick(1'b1, 3'd3, 6'b0_1000_0);
      idle(2 * FRM);
      tick(1'b1, 3'd3, 6'b1_1000_0);
      idle(2 * FRM);

      // Mid-slot write to the digit being lit
      tick(1'b1, 3'd5, {1'b1, 4'h2, 1'b1});
      for (int i = 0; i < 200 && !(((s / DIV) % 8) == 5 && (s % DIV) == 4); i++)
         idle(1);
      tick(1'b1, 3'd5, {1'b1, 4'h9, 1'b1});
      idle(2 * FRM);

      // Randomized writes, including back-to-back and same-address bursts
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 3) == 0)
            tick(1'b1, 3'($urandom_range(0, 7)), 6'($urandom_range(0, 63)));
         else
            idle(1);
      end

      // Asynchronous reset mid-slot: outputs blank before any edge
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      W = 1'b0;
      model_reset();
      #1;
      check_reset_outputs("reset_async_mid_slot");
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset_held");
      release_reset();

      // Light all digits, then reset on the same edge as a write to entry 2
      for (int n = 0; n < 8; n++) tick(1'b1, 3'(n), 6'b1_0101_0);
      idle(FRM + 5);
      tick(1'b1, 3'd2, 6'b1_0111_1);
      @(posedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      W = 1'b0;
      check_reset_outputs("reset_during_write");
      repeat (2) @(posedge clk);
      release_reset();
      idle(FRM + 10);

      // Entry 2 alone enabled again: the scan restarts at digit 0
      tick(1'b1, 3'd2, 6'b1_0001_1);
      idle(2 * FRM);

      idle(2);
      @(posedge clk);
      #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/display_scan_driver.md
# display_scan_driver

Eight-entry display register file plus multiplexed scan driver for the board's 8-digit common-anode seven-segment display. It sits directly downstream of the display controller, which writes one 6-bit character per entry over W/WADD/DIN. The block continuously refreshes the digits from its stored characters. It also emits a frame pulse each time the scan wraps, so upstream logic can align updates to the refresh.

## Interface
- REFRESH_DIV, 100000: dwell time of each digit slot in clk cycles (1 kHz per digit at 100 MHz); legal range ≥ 2.
- BLANK_CYCLES, 16: anti-ghosting guard at the start of each slot, in clk cycles, during which all anodes are off; legal range 0 .. REFRESH_DIV-1.
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- W  input  1  write strobe, active-high; sampled on rising clk.
- WADD  input  3  write address; entry 0 = rightmost digit, entry 7 = leftmost.
- DIN  input  6  character: [5] digit enable (1 = lit), [4:1] hex nibble, [0] decimal point (0 = lit, 1 = off).
- AN  output  8  anode drives, active-low, one-hot-low or all high.
- SEG  output  7  cathodes {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal-point cathode, active-low.
- FRAME  output  1  one-cycle pulse when the scan wraps from digit 7 to digit 0.

## Operation
- Register file: 8 × 6 bits. On a rising edge with W=1, entry WADD ← DIN. With W=0, the file holds.
- Scan state consists of the prescaler `pcnt` (0..REFRESH_DIV-1) and the digit index `d` (0..7).
  - `pcnt` increments every cycle.
  - When `pcnt` = REFRESH_DIV-1, `pcnt` ← 0 and `d` ← d+1 mod 8.
  - When that wrap takes `d` from 7 to 0, FRAME is registered high for exactly that one cycle.
- Output stage: all outputs are registered and computed from the state and register contents before the edge. With `e` = entry[d]:
  - SEG ← hexdecode(e[4:1]), in every cycle of the slot.
  - DP ← e[0].
  - AN ← all 1s if `pcnt` < BLANK_CYCLES or e[5] = 0; otherwise AN has bit d low and every other bit high.
- Hex decode, active-low {g..a}:
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E (all hex values)
- A disabled digit (e[5] = 0) is dark for its whole slot. SEG and DP are still driven, but no anode is active.
- Writes to the digit currently being scanned take effect mid-slot. No bypass and no deferral to the slot boundary.
- A write and a slot change in the same cycle are independent: the write lands, and the next slot reads from the updated file.

## Timing
- Reset (asynchronous, takes effect immediately on rst_n low, independent of clk):
  - all 8 entries ← 6'b000000, i.e. all digits disabled;
  - `pcnt` ← 0, `d` ← 0;
  - AN = 8'hFF, SEG = 7'h7F, DP = 1, FRAME = 0.
- Reset mid-scan or mid-write blanks the display immediately and discards the in-flight write. The first slot after release is digit 0, starting from `pcnt` = 0.
- Write-to-display latency: a write at edge t changes SEG, DP and AN at edge t+1, provided that entry is the current digit.
- Slot timing: digit d is selected for exactly REFRESH_DIV cycles. Its anode is low for REFRESH_DIV − BLANK_CYCLES of them, provided it is enabled. A full frame is 8·REFRESH_DIV cycles.
- FRAME period is 8·REFRESH_DIV cycles. The pulse is high in the first cycle in which digit 0's outputs are presented.
- The block never holds off or rejects the upstream writer. Back-to-back writes on every cycle are accepted, including repeated writes to the same address; the last write wins.

## Test plan
- Reset check, with REFRESH_DIV=8, BLANK_CYCLES=2:
  - Assert rst_n=0 mid-slot → AN=FF, SEG=7F, DP=1, FRAME=0 within the same cycle, before any clk edge.
  - After release with no writes, AN stays FF for 64+ cycles.
- Full frame, same parameters:
  - Write entries 7..0 with DIN = {1, n, 1}, n = 7..0, in one back-to-back burst.
  - → Each slot shows AN=FF for 2 cycles, then AN with only bit d low for 6 cycles.
  - → SEG matches the decode of d for all 8 cycles of the slot; DP=1.
  - → FRAME fires every 64 cycles.
- Decode sweep:
  - Write digit 0 with nibbles 0..F, holding each for one frame.
  - → SEG reads 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E during digit 0's slot.
- Enable and DP:
  - Entry 3 = 6'b0_1000_0 → digit 3 stays dark (AN=FF for its entire slot), while the other lit digits scan normally.
  - Entry 3 = 6'b1_1000_0 → AN=F7, SEG=00, DP=0 after the blank interval.
- Mid-slot write:
  - While digit 5 is lit showing 2, write entry 5 = {1, 9, 1} at cycle t.
  - → SEG changes 24→10 at t+1; AN is unchanged; the slot length is unchanged.
- Reset during a write burst:
  - Assert rst_n low on the same edge as W=1 to entry 2.
  - → After release, entry 2 reads as disabled (digit dark), and the scan restarts at digit 0 with `pcnt` = 0.
